// File: rtl/hello_pkg.sv
// Letter codes and FSM state encodings for the HELLO display sequencer.
// Shared with the downstream HexHELO decoder, so the codes must not drift.
package hello_pkg;

  localparam logic [3:0] ALLBLANK = 4'b0000;
  localparam logic [3:0] H        = 4'b0001;
  localparam logic [3:0] E        = 4'b0010;
  localparam logic [3:0] L        = 4'b0011;
  localparam logic [3:0] O        = 4'b0100;
  // Never 0000: downstream treats 0000 as "clear all digits".
  localparam logic [3:0] SPACE    = 4'b0111;

  typedef enum logic [3:0] {
    S_ALLBLANK = 4'd0,
    S_H        = 4'd1,
    S_E        = 4'd2,
    S_L1       = 4'd3,
    S_L2       = 4'd4,
    S_O        = 4'd5,
    S_SP1      = 4'd6,
    S_SP2      = 4'd7,
    S_SP3      = 4'd8,
    S_ROTATE   = 4'd9
  } state_e;

  function automatic logic [3:0] letter_of(input state_e s);
    case (s)
      S_ALLBLANK: return ALLBLANK;
      S_H:        return H;
      S_E:        return E;
      S_L1, S_L2: return L;
      S_O:        return O;
      default:    return SPACE;
    endcase
  endfunction

  function automatic logic shift_of(input state_e s);
    return (s == S_ROTATE);
  endfunction

  function automatic logic busy_of(input state_e s);
    case (s)
      S_H, S_E, S_L1, S_L2, S_O, S_SP1, S_SP2, S_SP3: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides Clk into a registered one-cycle Tick every TICKS enabled cycles.
// Clear restarts the period from zero and drops any pending Tick.
module tick_prescaler #(
  parameter int unsigned TICKS  = 50_000_000,
  parameter int unsigned TICK_W = 26
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS - 1);

  logic [TICK_W-1:0] count_q;
  logic              tick_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (Clear) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (Enable) begin
      if (count_q == LAST) begin
        count_q <= '0;
        tick_q  <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
        tick_q  <= 1'b0;
      end
    end else begin
      // Paused: hold the count so resuming neither loses nor adds a Tick.
      tick_q <= 1'b0;
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/hello_sequencer.sv
// Moore sequencer feeding the 8-digit HELLO shift register: clear, load
// "HELLO   ", then rotate one digit per Tick until Restart or Reset.
module hello_sequencer
  import hello_pkg::*;
#(
  parameter int unsigned TICKS  = 50_000_000,
  parameter int unsigned TICK_W = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Restart,
  output logic [3:0] LetterOut,
  output logic       ShiftMode,
  output logic       Tick,
  output logic       Busy
);

  logic       tick;
  state_e     state_q, state_d;
  logic [3:0] letter_q;
  logic       shift_q;
  logic       busy_q;

  tick_prescaler #(
    .TICKS  (TICKS),
    .TICK_W (TICK_W)
  ) u_prescaler (
    .Clk    (Clk),
    .Reset  (Reset),
    .Enable (Enable),
    .Clear  (Restart),
    .Tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ALLBLANK: if (tick) state_d = S_H;
      S_H:        if (tick) state_d = S_E;
      S_E:        if (tick) state_d = S_L1;
      S_L1:       if (tick) state_d = S_L2;
      S_L2:       if (tick) state_d = S_O;
      S_O:        if (tick) state_d = S_SP1;
      S_SP1:      if (tick) state_d = S_SP2;
      S_SP2:      if (tick) state_d = S_SP3;
      S_SP3:      if (tick) state_d = S_ROTATE;
      S_ROTATE:   state_d = S_ROTATE;
      default:    state_d = S_ALLBLANK;
    endcase
    if (Restart) state_d = S_ALLBLANK;
  end

  // Outputs are registered from the next state so they change only with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_ALLBLANK;
      letter_q <= ALLBLANK;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_of(state_d);
      shift_q  <= shift_of(state_d);
      busy_q   <= busy_of(state_d);
    end
  end

  assign LetterOut = letter_q;
  assign ShiftMode = shift_q;
  assign Busy      = busy_q;
  assign Tick      = tick;

endmodule

// File: tb/tb_hello_sequencer.sv
// Self-checking bench for hello_sequencer with a Tick-clocked display model.
module tb_hello_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Restart;
  logic [3:0] LetterOut;
  logic       ShiftMode;
  logic       Tick;
  logic       Busy;
  logic [3:0] big_letter;
  logic       big_shift;
  logic       big_tick;
  logic       big_busy;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic [3:0] letter;
    logic       shift;
    logic       busy;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] disp;

  always #5 Clk = ~Clk;

  hello_sequencer #(.TICKS(4), .TICK_W(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Restart   (Restart),
    .LetterOut (LetterOut),
    .ShiftMode (ShiftMode),
    .Tick      (Tick),
    .Busy      (Busy)
  );

  hello_sequencer u_big (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Restart   (Restart),
    .LetterOut (big_letter),
    .ShiftMode (big_shift),
    .Tick      (big_tick),
    .Busy      (big_busy)
  );

  // Downstream 8-digit shift register, clock-enabled by Tick.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) disp <= '0;
    else if (Tick) begin
      if (ShiftMode)              disp <= {disp[27:0], disp[31:28]};
      else if (LetterOut == 4'h0) disp <= '0;
      else                        disp <= {disp[27:0], LetterOut};
    end
  end

  task automatic do_reset();
    Reset   = 1'b1;
    Enable  = 1'b1;
    Restart = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic run_to_tick(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (Tick === 1'b1) seen++;
    end
    tests_run++;
    if (seen != n) begin
      fails++;
      $display("FAIL tick_timeout got %0d ticks want %0d", seen, n);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    Enable  = 1'b1;
    Restart = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if ({LetterOut, ShiftMode, Tick, Busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 0000000", {LetterOut, ShiftMode, Tick, Busy});
    end
    $display("[TB] reset outputs letter=%h shift=%b tick=%b busy=%b", LetterOut, ShiftMode, Tick, Busy);
  endtask

  task automatic test_tick_timing();
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      tests_run++;
      if (Tick !== ((c % 4) == 0)) begin
        fails++;
        $display("FAIL tick_timing cycle %0d got %b want %b", c, Tick, (c % 4) == 0);
      end
    end
    $display("[TB] tick timing over 12 cycles checked");
  endtask

  task automatic test_sequence();
    logic [3:0] letters [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h4,
                                 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
    exp_t e;
    int   n   = 0;
    int   cyc = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      e.letter = letters[i];
      e.shift  = (i >= 9);
      e.busy   = (i >= 1 && i <= 8);
      sb_q.push_back(e);
    end
    while (sb_q.size() > 0 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (Tick === 1'b1) begin
        e = sb_q.pop_front();
        n++;
        tests_run++;
        if (LetterOut !== e.letter || ShiftMode !== e.shift || Busy !== e.busy) begin
          fails++;
          $display("FAIL seq_tick%0d got letter=%h shift=%b busy=%b want letter=%h shift=%b busy=%b",
                   n, LetterOut, ShiftMode, Busy, e.letter, e.shift, e.busy);
        end
        $display("[TB] tick %0d letter=%h shift=%b busy=%b disp=%h", n, LetterOut, ShiftMode, Busy, disp);
        if (n == 10) begin
          tests_run++;
          if (disp !== 32'h1233_4777) begin
            fails++;
            $display("FAIL display_after_tick9 got %h want 12334777", disp);
          end
        end
        if (n == 11) begin
          tests_run++;
          if (disp !== 32'h2334_7771) begin
            fails++;
            $display("FAIL display_after_tick10 got %h want 23347771", disp);
          end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL seq_timeout got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_enable_pause();
    do_reset();
    run_to_tick(2);
    repeat (2) @(negedge Clk);
    Enable = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge Clk);
      tests_run++;
      if (Tick !== 1'b0 || LetterOut !== 4'h2) begin
        fails++;
        $display("FAIL pause_hold cycle %0d got tick=%b letter=%h want tick=0 letter=2", i, Tick, LetterOut);
      end
    end
    Enable = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (Tick !== 1'b0) begin
      fails++;
      $display("FAIL resume_early got tick=%b want 0", Tick);
    end
    @(negedge Clk);
    tests_run++;
    if (Tick !== 1'b1 || LetterOut !== 4'h2) begin
      fails++;
      $display("FAIL resume_tick got tick=%b letter=%h want tick=1 letter=2", Tick, LetterOut);
    end
    $display("[TB] enable pause/resume tick=%b letter=%h", Tick, LetterOut);
  endtask

  task automatic test_restart();
    do_reset();
    run_to_tick(6);
    tests_run++;
    if (LetterOut !== 4'h4 || Tick !== 1'b1) begin
      fails++;
      $display("FAIL restart_pre got letter=%h tick=%b want letter=4 tick=1", LetterOut, Tick);
    end
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
    tests_run++;
    if (LetterOut !== 4'h0 || Busy !== 1'b0 || Tick !== 1'b0) begin
      fails++;
      $display("FAIL restart_state got letter=%h busy=%b tick=%b want 0/0/0", LetterOut, Busy, Tick);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      tests_run++;
      if (Tick !== (c == 4) || LetterOut !== 4'h0) begin
        fails++;
        $display("FAIL restart_retick cycle %0d got tick=%b letter=%h want tick=%b letter=0",
                 c, Tick, LetterOut, c == 4);
      end
    end
    $display("[TB] restart in S_O -> letter=%h tick=%b", LetterOut, Tick);
  endtask

  task automatic test_async_reset();
    do_reset();
    run_to_tick(10);
    tests_run++;
    if (ShiftMode !== 1'b1) begin
      fails++;
      $display("FAIL rotate_reached got shift=%b want 1", ShiftMode);
    end
    #2 Reset = 1'b1;
    #1;
    tests_run++;
    if ({LetterOut, ShiftMode, Tick, Busy} !== 7'b0) begin
      fails++;
      $display("FAIL async_reset got %b want 0000000", {LetterOut, ShiftMode, Tick, Busy});
    end
    $display("[TB] async reset mid-cycle letter=%h shift=%b tick=%b", LetterOut, ShiftMode, Tick);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_big_params();
    do_reset();
    repeat (20) @(negedge Clk);
    tests_run++;
    if ({big_letter, big_shift, big_tick, big_busy} !== 7'b0) begin
      fails++;
      $display("FAIL big_params got %b want 0000000", {big_letter, big_shift, big_tick, big_busy});
    end
    $display("[TB] default TICKS instance idle letter=%h tick=%b", big_letter, big_tick);
  endtask

  initial begin
    test_reset();
    test_tick_timing();
    test_sequence();
    test_enable_pause();
    test_restart();
    test_async_reset();
    test_big_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
